// File: rtl/kv_proto_pkg.sv
// Shared key/value protocol definitions: reply header field offsets and
// the reply-stream parser state type.
package kv_proto_pkg;

  localparam int KEY_LSB   = 0;
  localparam int HIT_BIT   = 64;
  localparam int LEN_LSB   = 80;
  localparam int HDR_BYTES = 12;

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    VALUE = 2'd1,
    DRAIN = 2'd2
  } rep_state_t;

endpackage

// File: rtl/keep_popcount.sv
// Combinational byte count of a contiguous-from-bit-0 keep vector.
module keep_popcount #(
  parameter int KEEP_WIDTH = 64
) (
  input  logic [KEEP_WIDTH-1:0] keep,
  output logic [6:0]            cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) cnt = cnt + 7'(keep[i]);
  end

endmodule

// File: rtl/lkp_rep_depacketizer.sv
// Lookup-reply depacketizer: splits reply packets into a meta channel and a
// value-beat channel, flags malformed packets and drains what it cannot use.
module lkp_rep_depacketizer
  import kv_proto_pkg::*;
#(
  parameter int DATA_WIDTH      = 512,
  parameter int KEEP_WIDTH      = 64,
  parameter int LEN_WIDTH       = 16,
  parameter int MAX_VALUE_BYTES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_axis_valid,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic [KEEP_WIDTH-1:0] s_axis_keep,
  input  logic                  s_axis_last,
  input  logic [LEN_WIDTH-1:0]  s_axis_size,
  input  logic [15:0]           s_axis_src,
  input  logic [15:0]           s_axis_dst,
  output logic                  s_axis_ready,
  output logic                  m_meta_valid,
  output logic [63:0]           m_meta_key,
  output logic                  m_meta_hit,
  output logic [LEN_WIDTH-1:0]  m_meta_len,
  output logic [15:0]           m_meta_src,
  output logic [15:0]           m_meta_dst,
  input  logic                  m_meta_ready,
  output logic                  m_value_valid,
  output logic [DATA_WIDTH-1:0] m_value_data,
  output logic [KEEP_WIDTH-1:0] m_value_keep,
  output logic                  m_value_last,
  output logic                  m_value_err,
  input  logic                  m_value_ready,
  output logic [15:0]           err_cnt
);

  localparam logic [LEN_WIDTH-1:0] MAXV = LEN_WIDTH'(MAX_VALUE_BYTES);

  rep_state_t           state, nxt_state;
  logic                 run;
  logic [LEN_WIDTH-1:0] byte_cnt, exp_len;
  logic [6:0]           beat_bytes;
  logic                 rdy, accept;
  logic                 hdr_hit;
  logic [LEN_WIDTH-1:0] hdr_len, hdr_exp_size;
  logic [LEN_WIDTH-1:0] new_cnt, room;
  logic                 over, val_err;
  logic [KEEP_WIDTH-1:0] trim_keep;
  logic [1:0]           err_inc;
  logic [16:0]          err_sum;

  keep_popcount #(.KEEP_WIDTH(KEEP_WIDTH)) u_popcount (
    .keep (s_axis_keep),
    .cnt  (beat_bytes)
  );

  always_comb begin
    case (state)
      HDR:     rdy = !m_meta_valid;
      VALUE:   rdy = !m_value_valid || m_value_ready;
      default: rdy = 1'b1;
    endcase
  end

  // run holds the link stalled until the first clock after reset release
  assign s_axis_ready = run && rdy;
  assign accept       = s_axis_valid && s_axis_ready;

  assign hdr_hit      = s_axis_data[HIT_BIT];
  assign hdr_len      = s_axis_data[LEN_LSB +: LEN_WIDTH];
  assign hdr_exp_size = hdr_hit ? LEN_WIDTH'(HDR_BYTES) + hdr_len : LEN_WIDTH'(HDR_BYTES);

  assign new_cnt = byte_cnt + LEN_WIDTH'(beat_bytes);
  assign room    = MAXV - byte_cnt;
  // Reaching the cap on a non-last beat means more bytes follow: cut here.
  assign over    = (new_cnt > MAXV) || (new_cnt == MAXV && !s_axis_last);
  assign val_err = over || (s_axis_last && new_cnt != exp_len);

  always_comb begin
    for (int i = 0; i < KEEP_WIDTH; i++)
      trim_keep[i] = s_axis_keep[i] && (LEN_WIDTH'(i) < room);
  end

  always_comb begin
    nxt_state = state;
    err_inc   = 2'd0;
    if (accept) begin
      case (state)
        HDR: begin
          if (s_axis_size != hdr_exp_size) err_inc = err_inc + 2'd1;
          if (!hdr_hit) begin
            if (!s_axis_last) begin
              err_inc   = err_inc + 2'd1;
              nxt_state = DRAIN;
            end
          end else if (s_axis_last) begin
            if (hdr_len != '0) err_inc = err_inc + 2'd1;
          end else begin
            nxt_state = VALUE;
          end
        end
        VALUE: begin
          if (over) begin
            err_inc   = err_inc + 2'd1;
            nxt_state = s_axis_last ? HDR : DRAIN;
          end else if (s_axis_last) begin
            if (new_cnt != exp_len) err_inc = err_inc + 2'd1;
            nxt_state = HDR;
          end
        end
        default: if (s_axis_last) nxt_state = HDR;
      endcase
    end
  end

  assign err_sum = {1'b0, err_cnt} + 17'(err_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HDR;
      run           <= 1'b0;
      byte_cnt      <= '0;
      exp_len       <= '0;
      err_cnt       <= '0;
      m_meta_valid  <= 1'b0;
      m_meta_key    <= '0;
      m_meta_hit    <= 1'b0;
      m_meta_len    <= '0;
      m_meta_src    <= '0;
      m_meta_dst    <= '0;
      m_value_valid <= 1'b0;
      m_value_data  <= '0;
      m_value_keep  <= '0;
      m_value_last  <= 1'b0;
      m_value_err   <= 1'b0;
    end else begin
      run     <= 1'b1;
      state   <= nxt_state;
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];

      if (accept && state == HDR) begin
        m_meta_valid <= 1'b1;
        m_meta_key   <= s_axis_data[KEY_LSB +: 64];
        m_meta_hit   <= hdr_hit;
        m_meta_len   <= hdr_hit ? hdr_len : '0;
        m_meta_src   <= s_axis_src;
        m_meta_dst   <= s_axis_dst;
        exp_len      <= hdr_len;
        byte_cnt     <= '0;
      end else if (m_meta_valid && m_meta_ready) begin
        m_meta_valid <= 1'b0;
      end

      if (accept && state == VALUE) begin
        m_value_valid <= 1'b1;
        m_value_data  <= s_axis_data;
        m_value_keep  <= over ? trim_keep : s_axis_keep;
        m_value_last  <= over || s_axis_last;
        m_value_err   <= val_err;
        byte_cnt      <= new_cnt;
      end else if (m_value_valid && m_value_ready) begin
        m_value_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lkp_rep_depacketizer.sv
// Directed bench for the reply depacketizer: meta/value scoreboards fed by a
// negedge monitor, compared against hand-computed expectations.
module tb_lkp_rep_depacketizer;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_axis_valid = 1'b0;
  logic [DW-1:0] s_axis_data = '0;
  logic [KW-1:0] s_axis_keep = '0;
  logic          s_axis_last = 1'b0;
  logic [LW-1:0] s_axis_size = '0;
  logic [15:0]   s_axis_src = '0;
  logic [15:0]   s_axis_dst = '0;
  logic          s_axis_ready;
  logic          m_meta_valid;
  logic [63:0]   m_meta_key;
  logic          m_meta_hit;
  logic [LW-1:0] m_meta_len;
  logic [15:0]   m_meta_src;
  logic [15:0]   m_meta_dst;
  logic          m_meta_ready = 1'b1;
  logic          m_value_valid;
  logic [DW-1:0] m_value_data;
  logic [KW-1:0] m_value_keep;
  logic          m_value_last;
  logic          m_value_err;
  logic          m_value_ready = 1'b1;
  logic [15:0]   err_cnt;

  lkp_rep_depacketizer dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data), .s_axis_keep(s_axis_keep),
    .s_axis_last(s_axis_last), .s_axis_size(s_axis_size), .s_axis_src(s_axis_src),
    .s_axis_dst(s_axis_dst), .s_axis_ready(s_axis_ready),
    .m_meta_valid(m_meta_valid), .m_meta_key(m_meta_key), .m_meta_hit(m_meta_hit),
    .m_meta_len(m_meta_len), .m_meta_src(m_meta_src), .m_meta_dst(m_meta_dst),
    .m_meta_ready(m_meta_ready),
    .m_value_valid(m_value_valid), .m_value_data(m_value_data), .m_value_keep(m_value_keep),
    .m_value_last(m_value_last), .m_value_err(m_value_err), .m_value_ready(m_value_ready),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        tog = 1'b0;
  logic        vr_hold = 1'b1;
  logic        mr_hold = 1'b1;

  logic [63:0] mq_key[$];
  logic        mq_hit[$];
  logic [15:0] mq_len[$];
  logic [15:0] mq_src[$];
  logic [63:0] vq_keep[$];
  logic [63:0] vq_d0[$];
  logic        vq_last[$];
  logic        vq_err[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ready policy changes only just after the active edge
  always begin
    @(posedge clk);
    #1;
    m_value_ready = tog ? ~m_value_ready : vr_hold;
    m_meta_ready  = mr_hold;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_meta_valid && m_meta_ready) begin
        mq_key.push_back(m_meta_key);
        mq_hit.push_back(m_meta_hit);
        mq_len.push_back(m_meta_len);
        mq_src.push_back(m_meta_src);
      end
      if (m_value_valid && m_value_ready) begin
        vq_keep.push_back(m_value_keep);
        vq_d0.push_back(m_value_data[63:0]);
        vq_last.push_back(m_value_last);
        vq_err.push_back(m_value_err);
      end
    end
  end

  task automatic clear_q();
    mq_key.delete(); mq_hit.delete(); mq_len.delete(); mq_src.delete();
    vq_keep.delete(); vq_d0.delete(); vq_last.delete(); vq_err.delete();
  endtask

  function automatic logic [DW-1:0] mk_hdr(input logic [63:0] k, input logic h, input logic [15:0] l);
    logic [DW-1:0] d;
    d = '0;
    d[63:0]  = k;
    d[64]    = h;
    d[95:80] = l;
    return d;
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                           input logic [LW-1:0] sz, input logic [15:0] src);
    int n;
    s_axis_data  = d;
    s_axis_keep  = k;
    s_axis_last  = l;
    s_axis_size  = sz;
    s_axis_src   = src;
    s_axis_dst   = ~src;
    s_axis_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_axis_ready) break;
      n++;
      if (n > 300) begin
        chk("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_axis_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] FULL = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    settle(3);
    chk("rst_meta_valid", 64'(m_meta_valid), 64'd0);
    chk("rst_value_valid", 64'(m_value_valid), 64'd0);
    chk("rst_s_ready", 64'(s_axis_ready), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst_n = 1'b1;
    settle(2);

    // miss
    send_beat(mk_hdr(64'hDEAD_BEEF_0000_0001, 1'b0, 16'd0), 64'hFFF, 1'b1, 16'd12, 16'h0011);
    settle(4);
    chk("miss_meta_cnt", 64'(mq_key.size()), 64'd1);
    chk("miss_key", mq_key[0], 64'hDEAD_BEEF_0000_0001);
    chk("miss_hit", 64'(mq_hit[0]), 64'd0);
    chk("miss_len", 64'(mq_len[0]), 64'd0);
    chk("miss_src", 64'(mq_src[0]), 64'h0011);
    chk("miss_val_cnt", 64'(vq_keep.size()), 64'd0);
    chk("miss_err_cnt", 64'(err_cnt), 64'd0);
    clear_q();

    // hit, 100 bytes over two beats
    send_beat(mk_hdr(64'h0123_4567_89AB_CDEF, 1'b1, 16'd100), '0, 1'b0, 16'd112, 16'h0022);
    send_beat(DW'(64'hA1), FULL, 1'b0, 16'd0, 16'h0022);
    send_beat(DW'(64'hA2), 64'h0000_000F_FFFF_FFFF, 1'b1, 16'd0, 16'h0022);
    settle(4);
    chk("hit_meta_len", 64'(mq_len[0]), 64'd100);
    chk("hit_meta_hit", 64'(mq_hit[0]), 64'd1);
    chk("hit_val_cnt", 64'(vq_keep.size()), 64'd2);
    chk("hit_b0_keep", vq_keep[0], FULL);
    chk("hit_b0_last", 64'(vq_last[0]), 64'd0);
    chk("hit_b1_keep", vq_keep[1], 64'h0000_000F_FFFF_FFFF);
    chk("hit_b1_d0", vq_d0[1], 64'hA2);
    chk("hit_b1_last", 64'(vq_last[1]), 64'd1);
    chk("hit_b1_err", 64'(vq_err[1]), 64'd0);
    chk("hit_err_cnt", 64'(err_cnt), 64'd0);
    clear_q();

    // length mismatch: header says 64, one 32-byte beat
    send_beat(mk_hdr(64'h3, 1'b1, 16'd64), '0, 1'b0, 16'd76, 16'h0033);
    send_beat(DW'(64'hB1), 64'h0000_0000_FFFF_FFFF, 1'b1, 16'd0, 16'h0033);
    settle(4);
    chk("mm_val_cnt", 64'(vq_keep.size()), 64'd1);
    chk("mm_last", 64'(vq_last[0]), 64'd1);
    chk("mm_err", 64'(vq_err[0]), 64'd1);
    chk("mm_err_cnt", 64'(err_cnt), 64'd1);
    clear_q();

    // oversize: 2000-byte value, 32 full beats, only 1024 bytes forwarded
    send_beat(mk_hdr(64'h4, 1'b1, 16'd2000), '0, 1'b0, 16'd2012, 16'h0044);
    for (int i = 0; i < 32; i++)
      send_beat(DW'(64'(256 + i)), FULL, (i == 31), 16'd0, 16'h0044);
    settle(4);
    chk("ov_val_cnt", 64'(vq_keep.size()), 64'd16);
    chk("ov_b14_last", 64'(vq_last[14]), 64'd0);
    chk("ov_b15_last", 64'(vq_last[15]), 64'd1);
    chk("ov_b15_err", 64'(vq_err[15]), 64'd1);
    chk("ov_b15_d0", vq_d0[15], 64'd271);
    chk("ov_err_cnt", 64'(err_cnt), 64'd2);
    clear_q();
    send_beat(mk_hdr(64'h5, 1'b0, 16'd0), 64'hFFF, 1'b1, 16'd12, 16'h0055);
    settle(4);
    chk("ov_next_key", mq_key[0], 64'h5);
    chk("ov_next_err_cnt", 64'(err_cnt), 64'd2);
    clear_q();

    // backpressure: value ready toggles, meta ready held low for 20 cycles
    tog = 1'b1;
    mr_hold = 1'b0;
    settle(1);
    fork
      begin
        send_beat(mk_hdr(64'hA, 1'b1, 16'd128), '0, 1'b0, 16'd140, 16'h0066);
        send_beat(DW'(64'hC1), FULL, 1'b0, 16'd0, 16'h0066);
        send_beat(DW'(64'hC2), FULL, 1'b1, 16'd0, 16'h0066);
        send_beat(mk_hdr(64'hB, 1'b0, 16'd0), 64'hFFF, 1'b1, 16'd12, 16'h0077);
      end
      begin
        settle(12);
        chk("bp_vals_before_meta", 64'(vq_keep.size()), 64'd2);
        chk("bp_meta_held", 64'(mq_key.size()), 64'd0);
        chk("bp_hdr_stalled", 64'(s_axis_ready), 64'd0);
        settle(8);
        mr_hold = 1'b1;
      end
    join
    settle(6);
    tog = 1'b0;
    chk("bp_meta_cnt", 64'(mq_key.size()), 64'd2);
    chk("bp_meta0_key", mq_key[0], 64'hA);
    chk("bp_meta1_key", mq_key[1], 64'hB);
    chk("bp_val_cnt", 64'(vq_keep.size()), 64'd2);
    chk("bp_val0_d0", vq_d0[0], 64'hC1);
    chk("bp_val1_d0", vq_d0[1], 64'hC2);
    chk("bp_val1_last", 64'(vq_last[1]), 64'd1);
    settle(2);
    clear_q();

    // reset in the middle of a value stream
    send_beat(mk_hdr(64'hE, 1'b1, 16'd256), '0, 1'b0, 16'd268, 16'h0088);
    send_beat(DW'(64'hD1), FULL, 1'b0, 16'd0, 16'h0088);
    send_beat(DW'(64'hD2), FULL, 1'b0, 16'd0, 16'h0088);
    rst_n = 1'b0;
    settle(2);
    chk("mr_meta_valid", 64'(m_meta_valid), 64'd0);
    chk("mr_value_valid", 64'(m_value_valid), 64'd0);
    chk("mr_err_cnt", 64'(err_cnt), 64'd0);
    chk("mr_s_ready", 64'(s_axis_ready), 64'd0);
    rst_n = 1'b1;
    settle(2);
    clear_q();
    send_beat(mk_hdr(64'hF, 1'b1, 16'd256), '0, 1'b0, 16'd268, 16'h0099);
    for (int i = 0; i < 4; i++)
      send_beat(DW'(64'(16'hE0 + i)), FULL, (i == 3), 16'd0, 16'h0099);
    settle(4);
    chk("mr_meta_key", mq_key[0], 64'hF);
    chk("mr_meta_len", 64'(mq_len[0]), 64'd256);
    chk("mr_val_cnt", 64'(vq_keep.size()), 64'd4);
    chk("mr_b3_last", 64'(vq_last[3]), 64'd1);
    chk("mr_b3_err", 64'(vq_err[3]), 64'd0);
    chk("mr_b0_d0", vq_d0[0], 64'hE0);
    chk("mr_err_cnt_after", 64'(err_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
